// File: rtl/lfsr_axi_seq_master_if.sv
// rtl/lfsr_axi_seq_master_if.sv - AXI-Lite bus between the LFSR sequencer master and its register slave
interface lfsr_axi_seq_master_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] m_axi_awaddr;
  logic                  m_axi_awvalid;
  logic                  m_axi_awready;
  logic [DATA_WIDTH-1:0] m_axi_wdata;
  logic                  m_axi_wvalid;
  logic                  m_axi_wready;
  logic [1:0]            m_axi_bresp;
  logic                  m_axi_bvalid;
  logic                  m_axi_bready;
  logic [ADDR_WIDTH-1:0] m_axi_araddr;
  logic                  m_axi_arvalid;
  logic                  m_axi_arready;
  logic [DATA_WIDTH-1:0] m_axi_rdata;
  logic                  m_axi_rvalid;
  logic                  m_axi_rready;

  modport master (
    output m_axi_awaddr, m_axi_awvalid, input m_axi_awready,
    output m_axi_wdata, m_axi_wvalid, input m_axi_wready,
    input m_axi_bresp, m_axi_bvalid, output m_axi_bready,
    output m_axi_araddr, m_axi_arvalid, input m_axi_arready,
    input m_axi_rdata, m_axi_rvalid, output m_axi_rready
  );

  modport slave (
    input m_axi_awaddr, m_axi_awvalid, output m_axi_awready,
    input m_axi_wdata, m_axi_wvalid, output m_axi_wready,
    output m_axi_bresp, m_axi_bvalid, input m_axi_bready,
    input m_axi_araddr, m_axi_arvalid, output m_axi_arready,
    output m_axi_rdata, m_axi_rvalid, input m_axi_rready
  );
endinterface

// File: rtl/lfsr_axi_seq_master.sv
// rtl/lfsr_axi_seq_master.sv - AXI-Lite sequencer that programs the LFSR slave and streams its samples
// Optional watchdog on stalled AXI handshakes: define LFSR_SEQ_TIMEOUT_EN.
module lfsr_axi_seq_master #(
  parameter int ADDR_WIDTH  = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_SAMPLES = 16
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         start,
  input  logic [7:0]                   cfg_ctrl,
  input  logic [7:0]                   cfg_seed,
  input  logic [7:0]                   cfg_taps,
  lfsr_axi_seq_master_if.master        axi,
  output logic [7:0]                   sample_data,
  output logic                         sample_valid,
  input  logic                         sample_ready,
  output logic                         busy,
  output logic                         done,
  output logic                         error
);

  typedef enum logic [3:0] {
    IDLE, WR_STOP, WR_SEED, WR_TAPS, WR_EN, RD_ADDR, RD_DATA, OUT, WR_FINAL, DONE, ERR
  } state_t;

  localparam logic [7:0] NUM_LAST = 8'(NUM_SAMPLES);

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_n, araddr_q, araddr_n;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_n;
  logic                  awvalid_q, awvalid_n, wvalid_q, wvalid_n, bready_q, bready_n;
  logic                  arvalid_q, arvalid_n, rready_q, rready_n;
  logic                  aw_done_q, aw_done_n, w_done_q, w_done_n;
  logic [7:0]            sample_q, sample_n;
  logic                  svalid_q, svalid_n;
  logic [7:0]            count_q, count_n;
  logic                  busy_q, busy_n, done_q, done_n, error_q, error_n;
  logic [7:0]            ctrl_q, ctrl_n, seed_q, seed_n, taps_q, taps_n;

  logic aw_fire, w_fire, b_fire, ar_fire, r_fire, wd_expired;
  logic ld_wr, ld_rd, to_err;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [DATA_WIDTH-1:0] ld_data;

  assign aw_fire = awvalid_q & axi.m_axi_awready;
  assign w_fire  = wvalid_q  & axi.m_axi_wready;
  assign b_fire  = bready_q  & axi.m_axi_bvalid;
  assign ar_fire = arvalid_q & axi.m_axi_arready;
  assign r_fire  = rready_q  & axi.m_axi_rvalid;

`ifdef LFSR_SEQ_TIMEOUT_EN
  logic [7:0] wd_cnt;
  logic       wd_wait;
  assign wd_wait = (awvalid_q & ~axi.m_axi_awready) | (wvalid_q & ~axi.m_axi_wready) |
                   (bready_q & ~axi.m_axi_bvalid) | (arvalid_q & ~axi.m_axi_arready) |
                   (rready_q & ~axi.m_axi_rvalid);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wd_cnt <= 8'd0;
    end else if (aw_fire || w_fire || b_fire || ar_fire || r_fire || (state_n != state)) begin
      wd_cnt <= 8'd0;
    end else if (wd_wait && (wd_cnt != 8'hFF)) begin
      wd_cnt <= wd_cnt + 8'd1;
    end
  end
  assign wd_expired = (wd_cnt == 8'hFF);
`else
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      sample_q  <= 8'h00;
      svalid_q  <= 1'b0;
      count_q   <= 8'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      ctrl_q    <= 8'h00;
      seed_q    <= 8'h00;
      taps_q    <= 8'h00;
    end else begin
      state     <= state_n;
      awaddr_q  <= awaddr_n;
      araddr_q  <= araddr_n;
      wdata_q   <= wdata_n;
      awvalid_q <= awvalid_n;
      wvalid_q  <= wvalid_n;
      bready_q  <= bready_n;
      arvalid_q <= arvalid_n;
      rready_q  <= rready_n;
      aw_done_q <= aw_done_n;
      w_done_q  <= w_done_n;
      sample_q  <= sample_n;
      svalid_q  <= svalid_n;
      count_q   <= count_n;
      busy_q    <= busy_n;
      done_q    <= done_n;
      error_q   <= error_n;
      ctrl_q    <= ctrl_n;
      seed_q    <= seed_n;
      taps_q    <= taps_n;
    end
  end

  always_comb begin
    state_n   = state;
    awaddr_n  = awaddr_q;
    araddr_n  = araddr_q;
    wdata_n   = wdata_q;
    awvalid_n = awvalid_q;
    wvalid_n  = wvalid_q;
    bready_n  = bready_q;
    arvalid_n = arvalid_q;
    rready_n  = rready_q;
    aw_done_n = aw_done_q;
    w_done_n  = w_done_q;
    sample_n  = sample_q;
    svalid_n  = svalid_q;
    count_n   = count_q;
    busy_n    = busy_q;
    done_n    = 1'b0;
    error_n   = error_q;
    ctrl_n    = ctrl_q;
    seed_n    = seed_q;
    taps_n    = taps_q;
    ld_wr     = 1'b0;
    ld_rd     = 1'b0;
    ld_addr   = '0;
    ld_data   = '0;
    to_err    = 1'b0;

    case (state)
      IDLE, ERR: begin
        if (start) begin
          state_n = WR_STOP;
          busy_n  = 1'b1;
          error_n = 1'b0;
          count_n = 8'd0;
          ctrl_n  = cfg_ctrl;
          seed_n  = cfg_seed;
          taps_n  = cfg_taps;
          ld_wr   = 1'b1;
        end
      end
      WR_STOP, WR_SEED, WR_TAPS, WR_EN, WR_FINAL: begin
        if (aw_fire) begin
          awvalid_n = 1'b0;
          aw_done_n = 1'b1;
        end
        if (w_fire) begin
          wvalid_n = 1'b0;
          w_done_n = 1'b1;
        end
        if (b_fire) begin
          bready_n  = 1'b0;
          aw_done_n = 1'b0;
          w_done_n  = 1'b0;
          if (axi.m_axi_bresp != 2'b00) begin
            to_err = 1'b1;
          end else begin
            case (state)
              WR_STOP: begin
                state_n = WR_SEED;
                ld_wr   = 1'b1;
                ld_addr = ADDR_WIDTH'(4);
                ld_data = DATA_WIDTH'(seed_q);
              end
              WR_SEED: begin
                state_n = WR_TAPS;
                ld_wr   = 1'b1;
                ld_addr = ADDR_WIDTH'(8);
                ld_data = DATA_WIDTH'(taps_q);
              end
              WR_TAPS: begin
                state_n = WR_EN;
                ld_wr   = 1'b1;
                ld_data = DATA_WIDTH'(ctrl_q);
              end
              WR_EN: begin
                state_n = RD_ADDR;
                ld_rd   = 1'b1;
              end
              default: begin
                state_n = DONE;
                done_n  = 1'b1;
                busy_n  = 1'b0;
              end
            endcase
          end
        end else if (aw_done_n && w_done_n) begin
          bready_n = 1'b1;
        end
      end
      RD_ADDR: begin
        if (ar_fire) begin
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
          state_n   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (r_fire) begin
          sample_n = axi.m_axi_rdata[7:0];
          rready_n = 1'b0;
          svalid_n = 1'b1;
          state_n  = OUT;
        end
      end
      OUT: begin
        if (svalid_q && sample_ready) begin
          svalid_n = 1'b0;
          count_n  = count_q + 8'd1;
          if (count_n == NUM_LAST) begin
            state_n = WR_FINAL;
            ld_wr   = 1'b1;
          end else begin
            state_n = RD_ADDR;
            ld_rd   = 1'b1;
          end
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Next transaction is launched on the same edge that retires the previous one.
    if (ld_wr) begin
      awaddr_n  = ld_addr;
      wdata_n   = ld_data;
      awvalid_n = 1'b1;
      wvalid_n  = 1'b1;
      aw_done_n = 1'b0;
      w_done_n  = 1'b0;
    end
    if (ld_rd) begin
      araddr_n  = ADDR_WIDTH'(12);
      arvalid_n = 1'b1;
    end

    if (wd_expired) to_err = 1'b1;
    if (to_err) begin
      state_n   = ERR;
      awvalid_n = 1'b0;
      wvalid_n  = 1'b0;
      bready_n  = 1'b0;
      arvalid_n = 1'b0;
      rready_n  = 1'b0;
      svalid_n  = 1'b0;
      aw_done_n = 1'b0;
      w_done_n  = 1'b0;
      busy_n    = 1'b0;
      done_n    = 1'b0;
      error_n   = 1'b1;
    end
  end

  assign axi.m_axi_awaddr  = awaddr_q;
  assign axi.m_axi_awvalid = awvalid_q;
  assign axi.m_axi_wdata   = wdata_q;
  assign axi.m_axi_wvalid  = wvalid_q;
  assign axi.m_axi_bready  = bready_q;
  assign axi.m_axi_araddr  = araddr_q;
  assign axi.m_axi_arvalid = arvalid_q;
  assign axi.m_axi_rready  = rready_q;
  assign sample_data       = sample_q;
  assign sample_valid      = svalid_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign error             = error_q;

endmodule
